i2c_tx_fifo: RTL and testbench
==============================

I2C_TX_FIFO -- requirements
Module: i2c_tx_fifo

Interface
REQ-001 SHALL have parameter data_size, default 8, word width in bits.
REQ-002 SHALL have parameter depth, default 16, number of entries (power of two).
REQ-003 SHALL have parameter af_level, default 14, almost_full threshold.
REQ-004 SHALL have parameter ae_level, default 2, almost_empty threshold.
REQ-005 SHALL have port pclk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port presetn  input  1  asynchronous active-low reset.
REQ-007 SHALL have port wr_en  input  1  write strobe from the APB register stage (its new_data); may stay high several cycles.
REQ-008 SHALL have port wdata  input  data_size  write word.
REQ-009 SHALL have port rd_en  input  1  pop request from the I2C byte engine, level-sensitive.
REQ-010 SHALL have port rdata  output  data_size  head-of-queue word (first-word-fall-through).
REQ-011 SHALL have port full  output  1  count == depth.
REQ-012 SHALL have port empty  output  1  count == 0.
REQ-013 SHALL have port almost_full  output  1  count >= af_level.
REQ-014 SHALL have port almost_empty  output  1  count <= ae_level.
REQ-015 SHALL have port count  output  log2(depth)+1  current occupancy.
REQ-016 SHALL have port overflow  output  1  one-cycle pulse, push dropped.
REQ-017 SHALL have port underflow  output  1  one-cycle pulse, pop ignored.

Function
REQ-018 SHALL register wr_en into wr_en_d each cycle; push request = wr_en & ~wr_en_d (one push per strobe, irrespective of strobe length).
REQ-019 SHALL treat every cycle with rd_en high as one pop request.
REQ-020 Accepted push SHALL write wdata to mem[wr_ptr] and advance wr_ptr by 1, modulo depth.
REQ-021 Accepted pop SHALL advance rd_ptr by 1, modulo depth; the popped word is the rdata value in the cycle of the pop.
REQ-022 SHALL drive rdata = mem[rd_ptr] combinationally when not empty, and all-zero when empty.
REQ-023 A push SHALL become visible on rdata/empty in the cycle after the push edge (latency 1).
REQ-024 count SHALL be registered: +1 on push-only, -1 on pop-only, unchanged on push+pop or neither.
REQ-025 full, empty, almost_full, almost_empty SHALL be combinational decodes of registered count.
REQ-026 Push when full with no pop SHALL be dropped: memory, wr_ptr, count unchanged; overflow = 1 next cycle for one cycle.
REQ-027 Push when full with simultaneous pop SHALL be accepted; count stays depth.
REQ-028 Pop when empty SHALL be ignored: rd_ptr unchanged, underflow = 1 next cycle for one cycle; a simultaneous push SHALL still be accepted (count 0 -> 1).
REQ-029 Pointers SHALL wrap from depth-1 to 0 without affecting count or flags.
REQ-030 overflow and underflow SHALL be registered and SHALL deassert the cycle after assertion unless re-triggered.

Reset
REQ-031 presetn low SHALL immediately clear wr_ptr, rd_ptr, count, wr_en_d, overflow, underflow.
REQ-032 During and after reset: empty = 1, almost_empty = 1, full = 0, almost_full = 0, count = 0, rdata = 0.
REQ-033 Memory contents SHALL NOT be reset; never observable while empty.
REQ-034 Reset asserted mid-operation SHALL discard all queued data; wr_en high at reset release SHALL produce one push on the first active edge.

Verification
REQ-035 Reset release, wr_en=1 for 3 cycles with wdata=8'hA5 -> exactly one entry, count=1, rdata=8'hA5, empty=0.
REQ-036 16 strobes of 8'h00..8'h0F, then rd_en held high 16 cycles -> rdata sequence 00..0F, full=1 before draining, empty=1 after; almost_full set at count 14, almost_empty set at count 2.
REQ-037 Fill to 16, 17th strobe 8'hFF -> overflow pulse 1 cycle, count=16, 8'hFF never read.
REQ-038 Full, strobe 8'h55 with rd_en=1 same cycle -> head popped, count stays 16, 8'h55 read last.
REQ-039 Empty, rd_en=1 with push 8'h3C same cycle -> underflow pulse, count=1, rdata=8'h3C.
REQ-040 Push 10 / pop 10 three times (pointer wrap), then presetn low mid-stream -> data order preserved before reset; count=0, empty=1, rdata=0 immediately on reset.

Source files
------------

// File: rtl/i2c_tx_fifo.sv
// rtl/i2c_tx_fifo.sv - transmit byte queue between the APB register stage and the I2C byte engine
module i2c_tx_fifo #(
   parameter int data_size = 8,
   parameter int depth     = 16,
   parameter int af_level  = 14,
   parameter int ae_level  = 2
) (
   input  logic                   pclk,
   input  logic                   presetn,
   input  logic                   wr_en,
   input  logic [data_size-1:0]   wdata,
   input  logic                   rd_en,
   output logic [data_size-1:0]   rdata,
   output logic                   full,
   output logic                   empty,
   output logic                   almost_full,
   output logic                   almost_empty,
   output logic [$clog2(depth):0] count,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int AW = $clog2(depth);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(depth);
   localparam logic [CW-1:0] AF_C    = CW'(af_level);
   localparam logic [CW-1:0] AE_C    = CW'(ae_level);

   logic [data_size-1:0] mem_q [depth];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 wr_en_q;
   logic                 overflow_q, underflow_q;
   logic                 push_req, pop_ok, push_ok;

   // Status flags decode straight from the registered occupancy
   always_comb begin
      full         = (count_q == DEPTH_C);
      empty        = (count_q == '0);
      almost_full  = (count_q >= AF_C);
      almost_empty = (count_q <= AE_C);
   end

   // Push/pop qualification and next-state pointers/occupancy
   always_comb begin
      // A long write strobe from the register stage still yields a single push
      push_req = wr_en & ~wr_en_q;
      pop_ok   = rd_en & ~empty;
      // A pop in the same cycle frees the slot, so a push into a full queue is taken
      push_ok  = push_req & (~full | pop_ok);
      wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push_ok && !pop_ok) begin
         count_d = count_q + CW'(1);
      end else if (pop_ok && !push_ok) begin
         count_d = count_q - CW'(1);
      end
   end

   // Control state: pointers, occupancy, strobe history and error pulses
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         wr_en_q     <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         wr_en_q     <= wr_en;
         overflow_q  <= push_req & full & ~pop_ok;
         underflow_q <= rd_en & empty;
      end
   end

   // Storage array; left unreset since it is masked whenever the queue is empty
   always_ff @(posedge pclk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   // First-word-fall-through head, forced to zero when nothing is queued
   always_comb begin
      rdata = empty ? '0 : mem_q[rd_ptr_q];
   end

   assign count     = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: tb/tb_i2c_tx_fifo.sv
// tb/tb_i2c_tx_fifo.sv - randomized self-checking bench for i2c_tx_fifo against a queue model
module tb_i2c_tx_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AF    = 14;
   localparam int AE    = 2;

   logic          pclk    = 1'b0;
   logic          presetn = 1'b0;
   logic          wr_en   = 1'b0;
   logic          rd_en   = 1'b0;
   logic [DW-1:0] wdata   = '0;
   logic [DW-1:0] rdata;
   logic          full, empty, almost_full, almost_empty;
   logic [4:0]    count;
   logic          overflow, underflow;

   i2c_tx_fifo #(
      .data_size(DW),
      .depth    (DEPTH),
      .af_level (AF),
      .ae_level (AE)
   ) dut (
      .pclk        (pclk),
      .presetn     (presetn),
      .wr_en       (wr_en),
      .wdata       (wdata),
      .rd_en       (rd_en),
      .rdata       (rdata),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .almost_empty(almost_empty),
      .count       (count),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   always #5 pclk = ~pclk;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [DW-1:0] mq[$];
   logic          m_prev_wr = 1'b0;
   logic          m_ovf     = 1'b0;
   logic          m_udf     = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_state(input string ctx);
      int n;
      n = mq.size();
      check_eq({ctx, ".count"},     32'(count),        32'(n));
      check_eq({ctx, ".empty"},     32'(empty),        32'(n == 0));
      check_eq({ctx, ".full"},      32'(full),         32'(n == DEPTH));
      check_eq({ctx, ".afull"},     32'(almost_full),  32'(n >= AF));
      check_eq({ctx, ".aempty"},    32'(almost_empty), 32'(n <= AE));
      check_eq({ctx, ".rdata"},     32'(rdata),        (n > 0) ? 32'(mq[0]) : 32'd0);
      check_eq({ctx, ".overflow"},  32'(overflow),     32'(m_ovf));
      check_eq({ctx, ".underflow"}, 32'(underflow),    32'(m_udf));
   endtask

   // Queue semantics: a push is a rising strobe; a pop needs data; a pop frees room first
   task automatic model_edge(input logic w, input logic r, input logic [DW-1:0] d);
      bit push, pop;
      int pre;
      pre   = mq.size();
      push  = w && !m_prev_wr;
      pop   = r && (pre > 0);
      m_udf = r && (pre == 0);
      m_ovf = push && (pre == DEPTH) && !pop;
      if (pop) void'(mq.pop_front());
      if (push && mq.size() < DEPTH) mq.push_back(d);
      m_prev_wr = w;
   endtask

   task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input string ctx);
      wr_en = w;
      wdata = d;
      rd_en = r;
      @(posedge pclk);
      model_edge(w, r, d);
      @(negedge pclk);
      check_state(ctx);
   endtask

   task automatic strobe(input logic [DW-1:0] d, input logic r, input string ctx);
      step(1'b1, d, r, ctx);
      step(1'b0, 8'h00, 1'b0, ctx);
   endtask

   task automatic apply_reset(input logic wr_at_release);
      presetn = 1'b0;
      rd_en   = 1'b0;
      wr_en   = wr_at_release;
      #1;
      mq.delete();
      m_prev_wr = 1'b0;
      m_ovf     = 1'b0;
      m_udf     = 1'b0;
      check_state("rst_now");
      repeat (2) @(negedge pclk);
      check_state("rst_hold");
      presetn = 1'b1;
   endtask

   initial begin
      @(negedge pclk);

      // Held strobe across reset release gives exactly one entry
      apply_reset(1'b1);
      repeat (3) step(1'b1, 8'hA5, 1'b0, "hold_a5");
      check_eq("a5.count", 32'(count), 32'd1);
      check_eq("a5.rdata", 32'(rdata), 32'hA5);
      step(1'b0, 8'h00, 1'b0, "a5_idle");

      // Fill with 00..0F, overflow on 17th, push+pop while full, then drain
      apply_reset(1'b0);
      for (int i = 0; i < DEPTH; i++) strobe(DW'(i), 1'b0, "fill");
      check_eq("fill.full", 32'(full), 32'd1);
      step(1'b1, 8'hFF, 1'b0, "ovf");
      check_eq("ovf.pulse", 32'(overflow), 32'd1);
      step(1'b0, 8'h00, 1'b0, "ovf_clr");
      check_eq("ovf.clear", 32'(overflow), 32'd0);
      check_eq("ovf.count", 32'(count), 32'd16);
      step(1'b1, 8'h55, 1'b1, "full_pp");
      check_eq("full_pp.count", 32'(count), 32'd16);
      step(1'b0, 8'h00, 1'b0, "full_pp_idle");
      for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 8'h00, 1'b1, "drain");
      check_eq("drain.last55", 32'(rdata), 32'h55);
      step(1'b0, 8'h00, 1'b1, "drain_end");
      check_eq("drain.empty", 32'(empty), 32'd1);

      // Pop on empty with simultaneous push
      step(1'b1, 8'h3C, 1'b1, "udf");
      check_eq("udf.pulse", 32'(underflow), 32'd1);
      check_eq("udf.rdata", 32'(rdata), 32'h3C);
      step(1'b0, 8'h00, 1'b0, "udf_clr");
      step(1'b0, 8'h00, 1'b1, "udf_pop");

      // Pointer wrap: three rounds of push 10 / pop 10, then reset mid-stream
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 10; i++) strobe(DW'($urandom), 1'b0, "wrap_push");
         for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, "wrap_pop");
      end
      for (int i = 0; i < 5; i++) strobe(DW'($urandom), 1'b0, "pre_rst");
      apply_reset(1'b0);
      check_eq("midrst.count", 32'(count), 32'd0);

      // Randomized traffic with shifting read pressure and occasional resets
      for (int blk = 0; blk < 15; blk++) begin
         int rd_pct;
         rd_pct = $urandom_range(5, 95);
         for (int i = 0; i < 200; i++) begin
            logic w, r;
            w = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 99) < rd_pct);
            if ($urandom_range(0, 399) == 0) apply_reset(w);
            else step(w, DW'($urandom), r, "rand");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
